// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 keyboard definitions: prefix bytes, HID usages, modifier bit
// indices and the set-2 to HID translation used by the keyboard front end.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam int unsigned PAUSE_SKIP = 7;

    localparam logic [2:0] MOD_LCTRL  = 3'd0;
    localparam logic [2:0] MOD_LSHIFT = 3'd1;
    localparam logic [2:0] MOD_LALT   = 3'd2;
    localparam logic [2:0] MOD_LGUI   = 3'd3;
    localparam logic [2:0] MOD_RCTRL  = 3'd4;
    localparam logic [2:0] MOD_RSHIFT = 3'd5;
    localparam logic [2:0] MOD_RALT   = 3'd6;
    localparam logic [2:0] MOD_RGUI   = 3'd7;

    localparam logic [7:0] HID_NONE   = 8'h00;
    localparam logic [7:0] HID_1      = 8'h1E;
    localparam logic [7:0] HID_2      = 8'h1F;
    localparam logic [7:0] HID_3      = 8'h20;
    localparam logic [7:0] HID_4      = 8'h21;
    localparam logic [7:0] HID_5      = 8'h22;
    localparam logic [7:0] HID_6      = 8'h23;
    localparam logic [7:0] HID_7      = 8'h24;
    localparam logic [7:0] HID_8      = 8'h25;
    localparam logic [7:0] HID_9      = 8'h26;
    localparam logic [7:0] HID_0      = 8'h27;
    localparam logic [7:0] HID_ENTER  = 8'h28;
    localparam logic [7:0] HID_ESC    = 8'h29;
    localparam logic [7:0] HID_SPACE  = 8'h2C;
    localparam logic [7:0] HID_DELETE = 8'h4C;

    // Key event handed from the prefix decoder to the output stage.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    typedef struct packed {
        logic       is_mod;
        logic [2:0] mod_idx;
        logic       is_key;
        logic [7:0] hid;
    } hid_map_t;

    function automatic hid_map_t mod_entry(input logic [2:0] idx);
        hid_map_t m;
        m         = '0;
        m.is_mod  = 1'b1;
        m.mod_idx = idx;
        return m;
    endfunction

    function automatic hid_map_t key_entry(input logic [7:0] hid);
        hid_map_t m;
        m        = '0;
        m.is_key = 1'b1;
        m.hid    = hid;
        return m;
    endfunction

    // E0-prefixed shifts (fake shifts) fall through to the default and are ignored.
    function automatic hid_map_t ps2_to_hid(input logic ext, input logic [7:0] code);
        hid_map_t m;
        m = '0;
        case ({ext, code})
            9'h014:  m = mod_entry(MOD_LCTRL);
            9'h012:  m = mod_entry(MOD_LSHIFT);
            9'h011:  m = mod_entry(MOD_LALT);
            9'h11F:  m = mod_entry(MOD_LGUI);
            9'h114:  m = mod_entry(MOD_RCTRL);
            9'h059:  m = mod_entry(MOD_RSHIFT);
            9'h111:  m = mod_entry(MOD_RALT);
            9'h127:  m = mod_entry(MOD_RGUI);
            9'h016:  m = key_entry(HID_1);
            9'h01E:  m = key_entry(HID_2);
            9'h026:  m = key_entry(HID_3);
            9'h025:  m = key_entry(HID_4);
            9'h02E:  m = key_entry(HID_5);
            9'h036:  m = key_entry(HID_6);
            9'h03D:  m = key_entry(HID_7);
            9'h03E:  m = key_entry(HID_8);
            9'h046:  m = key_entry(HID_9);
            9'h045:  m = key_entry(HID_0);
            9'h029:  m = key_entry(HID_SPACE);
            9'h05A:  m = key_entry(HID_ENTER);
            9'h076:  m = key_entry(HID_ESC);
            9'h171:  m = key_entry(HID_DELETE);
            9'h15A:  m = key_entry(HID_ENTER);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pad synchronizer, glitch filter,
// start/data/parity/stop bit FSM and mid-frame timeout.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 28000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       filt_q;
    logic [FLT_W-1:0] flt_cnt_q [2];
    logic             clk_prev_q;
    logic             fall_c;
    logic             dat_c;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             err_q, err_d;

    // A line level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
        end else begin
            meta_q     <= {ps2_dat_i, ps2_clk_i};
            sync_q     <= meta_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FLT_W'(FILTER_LEN - 1)) begin
                    filt_q[i]    <= sync_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall_c = clk_prev_q & ~filt_q[0];
    assign dat_c  = filt_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_ok_d     = par_ok_q;
        tmo_d        = tmo_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;

        if (state_q != ST_IDLE) tmo_d = tmo_q + 1'b1;
        if (fall_c)             tmo_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (fall_c && !dat_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall_c) begin
                    shreg_d   = {dat_c, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall_c) begin
                    par_ok_d = ^{shreg_q, dat_c};
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    if (dat_c && par_ok_q) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shreg_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stalled keyboard: abandon the partial frame.
        if (state_q != ST_IDLE && !fall_c && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
        end
    end

    assign rx_byte_o    = rx_byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_hid_decoder.sv
// PS/2 set-2 keyboard front end: strips E0/F0/E1 prefixes, tracks modifiers and
// the last held mapped key, and presents them as HID level outputs.
module ps2_hid_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 28000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kbd_status,
    output logic [7:0] kbd_data,
    output logic       kbd_strobe,
    output logic       rx_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    key_event_t ev_q, ev_d;
    logic       ev_valid_q, ev_valid_d;

    logic [7:0] status_q, status_d;
    logic [7:0] data_q, data_d;
    logic       strobe_q, strobe_d;
    logic       err_q;
    hid_map_t   map_c;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_dat_i    (ps2_dat),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            ev_q       <= '0;
            ev_valid_q <= 1'b0;
            status_q   <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            ev_q       <= ev_d;
            ev_valid_q <= ev_valid_d;
            status_q   <= status_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            err_q      <= frame_err;
        end
    end

    // Prefix decoder: folds E0/F0 into the next key code, swallows the Pause run.
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        ev_d       = ev_q;
        ev_valid_d = 1'b0;

        if (frame_err) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (byte_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end else begin
                case (rx_byte)
                    PS2_EXT:   ext_d  = 1'b1;
                    PS2_BRK:   brk_d  = 1'b1;
                    PS2_PAUSE: skip_d = 3'(PAUSE_SKIP);
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: begin
                        ev_valid_d = 1'b1;
                        ev_d.ext   = ext_q;
                        ev_d.brk   = brk_q;
                        ev_d.code  = rx_byte;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                endcase
            end
        end
    end

    // Output stage: modifier bits follow make/break, kbd_data holds the last make.
    always_comb begin
        map_c    = ps2_to_hid(ev_q.ext, ev_q.code);
        status_d = status_q;
        data_d   = data_q;

        if (ev_valid_q) begin
            if (map_c.is_mod) status_d[map_c.mod_idx] = ~ev_q.brk;
            if (map_c.is_key) begin
                if (!ev_q.brk)                data_d = map_c.hid;
                else if (map_c.hid == data_q) data_d = HID_NONE;
            end
        end

        strobe_d = (status_d != status_q) || (data_d != data_q);
    end

    assign kbd_status = status_q;
    assign kbd_data   = data_q;
    assign kbd_strobe = strobe_q;
    assign rx_err     = err_q;

endmodule

// File: tb/tb_ps2_hid_decoder.sv
// Directed bench for ps2_hid_decoder: bit-banged PS/2 frames with hand-computed
// HID expectations, plus a monitor tracking strobe/error pulses.
module tb_ps2_hid_decoder;

    localparam int unsigned TMO = 28000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] kbd_status;
    logic [7:0] kbd_data;
    logic       kbd_strobe;
    logic       rx_err;

    int nvec = 0;
    int nfail = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int strobe_bad = 0;
    logic [7:0] prev_s = 8'h00;
    logic [7:0] prev_d = 8'h00;

    ps2_hid_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .kbd_status (kbd_status),
        .kbd_data   (kbd_data),
        .kbd_strobe (kbd_strobe),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    // Pulse counters; a strobe must coincide exactly with an output change.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (kbd_strobe === 1'b1) strobe_cnt++;
            if (rx_err === 1'b1) err_cnt++;
            if (kbd_strobe !== ((kbd_status !== prev_s) || (kbd_data !== prev_d))) strobe_bad++;
        end
        prev_s = kbd_status;
        prev_d = kbd_data;
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input bit bad_stop = 1'b0, input int nfall = 11);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfall; i++) begin
            ps2_dat = bits[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_dat = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic clear_counts();
        @(negedge clk);
        strobe_cnt = 0;
        err_cnt    = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        nvec++; if (kbd_status !== 8'h00) begin nfail++; $display("FAIL reset_status: got %h want 00", kbd_status); end
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL reset_data: got %h want 00", kbd_data); end
        nvec++; if (kbd_strobe !== 1'b0) begin nfail++; $display("FAIL reset_strobe: got %b want 0", kbd_strobe); end
        nvec++; if (rx_err !== 1'b0) begin nfail++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_make_break();
        clear_counts();
        send_frame(8'h16);
        nvec++; if (kbd_data !== 8'h1E) begin nfail++; $display("FAIL make16_data: got %h want 1e", kbd_data); end
        nvec++; if (strobe_cnt !== 1) begin nfail++; $display("FAIL make16_strobes: got %0d want 1", strobe_cnt); end
        send_frame(8'hF0); send_frame(8'h16);
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL brk16_data: got %h want 00", kbd_data); end
        nvec++; if (strobe_cnt !== 2) begin nfail++; $display("FAIL brk16_strobes: got %0d want 2", strobe_cnt); end
    endtask

    task automatic test_modifiers();
        send_frame(8'h14); send_frame(8'h11); send_frame(8'hE0); send_frame(8'h71);
        nvec++; if (kbd_status !== 8'h05) begin nfail++; $display("FAIL mod_status: got %h want 05", kbd_status); end
        nvec++; if (kbd_data !== 8'h4C) begin nfail++; $display("FAIL ext71_data: got %h want 4c", kbd_data); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h71);
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL ext71_brk_data: got %h want 00", kbd_data); end
        nvec++; if (kbd_status !== 8'h05) begin nfail++; $display("FAIL ext71_brk_status: got %h want 05", kbd_status); end
        // Fake shift ignored, right ctrl sets b4, left ctrl/alt released.
        send_frame(8'hE0); send_frame(8'h12);
        send_frame(8'hE0); send_frame(8'h14);
        send_frame(8'hF0); send_frame(8'h14);
        send_frame(8'hF0); send_frame(8'h11);
        nvec++; if (kbd_status !== 8'h10) begin nfail++; $display("FAIL rctrl_status: got %h want 10", kbd_status); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h14);
        nvec++; if (kbd_status !== 8'h00) begin nfail++; $display("FAIL rctrl_brk_status: got %h want 00", kbd_status); end
    endtask

    task automatic test_ignored_bytes();
        send_frame(8'hE0); send_frame(8'hFA); send_frame(8'h71);
        nvec++; if (kbd_data !== 8'h4C) begin nfail++; $display("FAIL ignored_keeps_ext: got %h want 4c", kbd_data); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h71);
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL ignored_cleanup: got %h want 00", kbd_data); end
    endtask

    task automatic test_parity_err();
        clear_counts();
        send_frame(8'h1E, 1'b1);
        nvec++; if (err_cnt !== 1) begin nfail++; $display("FAIL parity_err_pulses: got %0d want 1", err_cnt); end
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL parity_err_data: got %h want 00", kbd_data); end
        send_frame(8'h1E);
        nvec++; if (kbd_data !== 8'h1F) begin nfail++; $display("FAIL after_parity_data: got %h want 1f", kbd_data); end
        send_frame(8'h16, 1'b0, 1'b1);
        nvec++; if (err_cnt !== 2) begin nfail++; $display("FAIL stop_err_pulses: got %0d want 2", err_cnt); end
        nvec++; if (kbd_data !== 8'h1F) begin nfail++; $display("FAIL stop_err_data: got %h want 1f", kbd_data); end
        send_frame(8'hF0); send_frame(8'h1E);
    endtask

    task automatic test_timeout();
        clear_counts();
        send_frame(8'h45, 1'b0, 1'b0, 6);
        nvec++; if (err_cnt !== 0) begin nfail++; $display("FAIL timeout_early: got %0d want 0", err_cnt); end
        repeat (TMO + 100) @(posedge clk);
        nvec++; if (err_cnt !== 1) begin nfail++; $display("FAIL timeout_pulses: got %0d want 1", err_cnt); end
        send_frame(8'h26);
        nvec++; if (kbd_data !== 8'h20) begin nfail++; $display("FAIL after_timeout_data: got %h want 20", kbd_data); end
        send_frame(8'hF0); send_frame(8'h26);
    endtask

    task automatic test_pause();
        clear_counts();
        send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
        send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
        nvec++; if (strobe_cnt !== 0) begin nfail++; $display("FAIL pause_strobes: got %0d want 0", strobe_cnt); end
        nvec++; if (kbd_status !== 8'h00) begin nfail++; $display("FAIL pause_status: got %h want 00", kbd_status); end
        send_frame(8'h29);
        nvec++; if (kbd_data !== 8'h2C) begin nfail++; $display("FAIL after_pause_data: got %h want 2c", kbd_data); end
        send_frame(8'hF0); send_frame(8'h29);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12);
        send_frame(8'h16); send_frame(8'h1E);
        clear_counts();
        send_frame(8'hF0); send_frame(8'h16);
        nvec++; if (kbd_data !== 8'h1F) begin nfail++; $display("FAIL other_break_data: got %h want 1f", kbd_data); end
        send_frame(8'h1E); send_frame(8'h1E); send_frame(8'h1E);
        nvec++; if (strobe_cnt !== 0) begin nfail++; $display("FAIL typematic_strobes: got %0d want 0", strobe_cnt); end
        nvec++; if (kbd_status !== 8'h02) begin nfail++; $display("FAIL lshift_status: got %h want 02", kbd_status); end
        nvec++; if (strobe_bad !== 0) begin nfail++; $display("FAIL strobe_alignment: got %0d bad cycles want 0", strobe_bad); end
        // Reset in the middle of a frame clears everything without a clock edge.
        send_frame(8'h36, 1'b0, 1'b0, 5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        nvec++; if (kbd_status !== 8'h00) begin nfail++; $display("FAIL midreset_status: got %h want 00", kbd_status); end
        nvec++; if (kbd_data !== 8'h00) begin nfail++; $display("FAIL midreset_data: got %h want 00", kbd_data); end
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h16);
        nvec++; if (kbd_data !== 8'h1E) begin nfail++; $display("FAIL post_reset_data: got %h want 1e", kbd_data); end
        nvec++; if (kbd_status !== 8'h00) begin nfail++; $display("FAIL post_reset_status: got %h want 00", kbd_status); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_modifiers();
        test_ignored_bytes();
        test_parity_err();
        test_timeout();
        test_pause();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
